// File: rtl/tdm_pkg.sv
// Shared types and elaboration helpers for the TDM deserializer.
package tdm_pkg;

    typedef enum logic [1:0] {IDLE, HUNT, LOCK} state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // TOTAL: bits per frame
    function automatic int unsigned tdm_total(input int unsigned nch, input int unsigned wbits);
        return nch * wbits;
    endfunction

    // L: slot index captured on the fs-rise sample edge
    function automatic int unsigned tdm_l(input int unsigned total, input int unsigned fs_delay);
        return (total - fs_delay) % total;
    endfunction

endpackage

// File: rtl/tdm_edge_sync.sv
// Synchronises sclk/fs/tdmin into clk and strobes samp on the selected sclk edge.
module tdm_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic sclk,
    input  logic fs,
    input  logic tdmin,
    input  logic sample_neg,
    output logic samp,
    output logic fs_s,
    output logic din_s
);

    logic [SYNC_STAGES-1:0] sclk_q, fs_q, din_q;
    logic                   sclk_prev_q;
    logic                   sclk_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_q      <= '0;
            fs_q        <= '0;
            din_q       <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk};
            fs_q        <= {fs_q[SYNC_STAGES-2:0], fs};
            din_q       <= {din_q[SYNC_STAGES-2:0], tdmin};
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign fs_s   = fs_q[SYNC_STAGES-1];
    assign din_s  = din_q[SYNC_STAGES-1];
    assign samp   = sample_neg ? (sclk_prev_q & ~sclk_s) : (~sclk_prev_q & sclk_s);

endmodule

// File: rtl/tdm_deser.sv
// TDM serial-to-parallel deserializer with frame lock, fs error detection and resync.
// Define TDM_CHSTREAM_EN to add the per-channel outputs ch_valid/ch_idx/ch_data.
module tdm_deser
    import tdm_pkg::*;
#(
    parameter int unsigned NCH         = 8,
    parameter int unsigned WBITS       = 32,
    parameter int unsigned FS_DELAY    = 1,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned CW         = (clog2(NCH) > 0) ? clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 sample_neg,
    input  logic                 sclk,
    input  logic                 fs,
    input  logic                 tdmin,
    output logic                 valid,
    output logic [NCH*WBITS-1:0] pdata,
    output logic                 locked,
    output logic                 frame_err
`ifdef TDM_CHSTREAM_EN
    ,
    output logic                 ch_valid,
    output logic [CW-1:0]        ch_idx,
    output logic [WBITS-1:0]     ch_data
`endif
);

    localparam int unsigned   TOTAL = tdm_total(NCH, WBITS);
    localparam int unsigned   L     = tdm_l(TOTAL, FS_DELAY);
    localparam int unsigned   IW    = clog2(TOTAL);
    localparam logic [IW-1:0] LIDX  = IW'(L);
    localparam logic [IW-1:0] LAST  = IW'(TOTAL - 1);
    localparam logic [IW-1:0] LNEXT = IW'((L + 1) % TOTAL);
    localparam logic          ARM   = (FS_DELAY != 0);

    logic samp, fs_s, din_s, fs_rise;

    state_t           state_q, state_d;
    logic [IW-1:0]    index_q, index_d;
    logic [TOTAL-1:0] shreg_q, shreg_d;
    logic             fs_prev_q, fs_prev_d;
    logic             supp_q, supp_d;
    logic             comp_q, comp_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             valid_q;
    logic [TOTAL-1:0] pdata_q;
`ifdef TDM_CHSTREAM_EN
    logic             chc_q, chc_d;
    logic [CW-1:0]    chn_q, chn_d;
    logic             chv_q;
    logic [CW-1:0]    chi_q;
    logic [WBITS-1:0] chd_q;
`endif

    tdm_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rstn       (rstn),
        .sclk       (sclk),
        .fs         (fs),
        .tdmin      (tdmin),
        .sample_neg (sample_neg),
        .samp       (samp),
        .fs_s       (fs_s),
        .din_s      (din_s)
    );

    assign fs_rise = samp & fs_s & ~fs_prev_q;

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        shreg_d   = shreg_q;
        fs_prev_d = samp ? fs_s : fs_prev_q;
        supp_d    = supp_q;
        comp_d    = 1'b0;
        locked_d  = locked_q;
        err_d     = 1'b0;
`ifdef TDM_CHSTREAM_EN
        chc_d     = 1'b0;
        chn_d     = chn_q;
`endif
        if (!enable) begin
            state_d  = IDLE;
            index_d  = '0;
            shreg_d  = '0;
            supp_d   = 1'b0;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = HUNT;
                HUNT: begin
                    if (fs_rise) begin
                        shreg_d[TOTAL-1-L] = din_s;
                        index_d  = LNEXT;
                        supp_d   = ARM;
                        locked_d = 1'b1;
                        state_d  = LOCK;
                    end
                end
                LOCK: begin
                    if (samp) begin
                        if (fs_rise && index_q != LIDX) begin
                            // Resync: restart the frame at slot L, drop the partial one
                            err_d = 1'b1;
                            shreg_d[TOTAL-1-L] = din_s;
                            index_d = LNEXT;
                            supp_d  = ARM;
                        end else if (!fs_rise && index_q == LIDX) begin
                            err_d    = 1'b1;
                            locked_d = 1'b0;
                            index_d  = '0;
                            state_d  = HUNT;
                        end else begin
                            shreg_d[LAST - index_q] = din_s;
                            index_d = (index_q == LAST) ? '0 : index_q + 1'b1;
                            if (index_q == LAST) begin
                                if (supp_q) supp_d = 1'b0;
                                else        comp_d = 1'b1;
                            end
`ifdef TDM_CHSTREAM_EN
                            if ((32'(index_q) % WBITS) == WBITS - 1 && !supp_q) begin
                                chc_d = 1'b1;
                                chn_d = CW'(32'(index_q) / WBITS);
                            end
`endif
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            index_q   <= '0;
            shreg_q   <= '0;
            fs_prev_q <= 1'b0;
            supp_q    <= 1'b0;
            comp_q    <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            pdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            shreg_q   <= shreg_d;
            fs_prev_q <= fs_prev_d;
            supp_q    <= supp_d;
            comp_q    <= comp_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            valid_q   <= comp_q & enable;
            if (comp_q && enable) pdata_q <= shreg_q;
        end
    end

    assign valid     = valid_q;
    assign pdata     = pdata_q;
    assign locked    = locked_q;
    assign frame_err = err_q;

`ifdef TDM_CHSTREAM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chc_q <= 1'b0;
            chn_q <= '0;
            chv_q <= 1'b0;
            chi_q <= '0;
            chd_q <= '0;
        end else begin
            chc_q <= chc_d;
            chn_q <= chn_d;
            chv_q <= chc_q & enable;
            if (chc_q && enable) begin
                chi_q <= chn_q;
                chd_q <= WBITS'(shreg_q >> (WBITS * (NCH - 1 - 32'(chn_q))));
            end
        end
    end

    assign ch_valid = chv_q;
    assign ch_idx   = chi_q;
    assign ch_data  = chd_q;
`endif

endmodule

// File: tb/tb_tdm_deser.sv
// Directed bench for tdm_deser: default 8x32 instance plus a 4x16, FS_DELAY=0, falling-edge one.
module tb_tdm_deser;

    logic clk = 1'b0;
    logic rstn = 1'b1;

    logic en1 = 1'b0, sneg1 = 1'b0, sclk1 = 1'b0, fs1 = 1'b0, din1 = 1'b0;
    logic valid1, locked1, ferr1;
    logic [255:0] pdata1;

    logic en2 = 1'b0, sneg2 = 1'b1, sclk2 = 1'b1, fs2 = 1'b0, din2 = 1'b0;
    logic valid2, locked2, ferr2;
    logic [63:0] pdata2;

`ifdef TDM_CHSTREAM_EN
    logic chv1, chv2;
    logic [2:0] chi1;
    logic [1:0] chi2;
    logic [31:0] chd1;
    logic [15:0] chd2;
`endif

    always #5 clk = ~clk;

    tdm_deser u_dut1 (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (en1),
        .sample_neg (sneg1),
        .sclk       (sclk1),
        .fs         (fs1),
        .tdmin      (din1),
        .valid      (valid1),
        .pdata      (pdata1),
        .locked     (locked1),
        .frame_err  (ferr1)
`ifdef TDM_CHSTREAM_EN
        ,
        .ch_valid   (chv1),
        .ch_idx     (chi1),
        .ch_data    (chd1)
`endif
    );

    tdm_deser #(
        .NCH      (4),
        .WBITS    (16),
        .FS_DELAY (0)
    ) u_dut2 (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (en2),
        .sample_neg (sneg2),
        .sclk       (sclk2),
        .fs         (fs2),
        .tdmin      (din2),
        .valid      (valid2),
        .pdata      (pdata2),
        .locked     (locked2),
        .frame_err  (ferr2)
`ifdef TDM_CHSTREAM_EN
        ,
        .ch_valid   (chv2),
        .ch_idx     (chi2),
        .ch_data    (chd2)
`endif
    );

    // Event monitors, sampled away from the active edge
    int vcnt1 = 0, ecnt1 = 0, lfall1 = 0, vcnt2 = 0, ecnt2 = 0;
    logic lock1_d = 1'b0;
    logic [255:0] vq1[$];
    logic [63:0]  vq2[$];
    int chq1[$];

    always @(negedge clk) begin
        if (valid1) begin
            vcnt1 <= vcnt1 + 1;
            vq1.push_back(pdata1);
        end
        if (ferr1) ecnt1 <= ecnt1 + 1;
        if (lock1_d && !locked1) lfall1 <= lfall1 + 1;
        lock1_d <= locked1;
        if (valid2) begin
            vcnt2 <= vcnt2 + 1;
            vq2.push_back(pdata2);
        end
        if (ferr2) ecnt2 <= ecnt2 + 1;
`ifdef TDM_CHSTREAM_EN
        if (chv1) chq1.push_back(int'(chi1));
`endif
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] gen1(input int seed);
        logic [255:0] v;
        for (int k = 1; k <= 8; k++)
            v[256-32*k +: 32] = 32'hA500_0000 + (32'(seed) << 16) + 32'(k);
        return v;
    endfunction

    // One sclk bit for dut1: data changes on the falling edge, sampled on rising
    task automatic send1(input logic f, input logic d);
        sclk1 = 1'b0;
        fs1   = f;
        din1  = d;
        #30;
        sclk1 = 1'b1;
        #30;
    endtask

    // One sclk bit for dut2: data changes on the rising edge, sampled on falling
    task automatic send2(input logic f, input logic d);
        sclk2 = 1'b1;
        fs2   = f;
        din2  = d;
        #30;
        sclk2 = 1'b0;
        #30;
    endtask

    // FS_DELAY=1: fs rides on the bit before each CH1 MSB (the previous frame's LSB)
    task automatic play1(input int nfr, input int early_f, input int skip_f, input int vary);
        logic [255:0] fr;
        int len;
        send1(1'b0, 1'b0);
        send1(1'b0, 1'b0);
        send1(1'b1, 1'b0);
        for (int f = 0; f < nfr; f++) begin
            fr  = gen1(vary != 0 ? f : 0);
            len = (f == early_f) ? 251 : 256;
            for (int b = 0; b < len; b++)
                send1((b == len - 1) && (f != skip_f), fr[255-b]);
        end
        for (int i = 0; i < 3; i++) send1(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        #1;
    endtask

    typedef struct {
        int nfr;
        int early_f;
        int skip_f;
        int vary;
        int exp_v;
        int exp_e;
        int exp_fall;
        int exp_seed;
    } scen_t;

    scen_t tbl[3];

    initial begin
        int bv, be, bf, bq, bc;
        logic [255:0] last;
        logic [63:0] fa, fb;

        tbl[0] = '{nfr: 3, early_f: -1, skip_f: -1, vary: 0,
                   exp_v: 2, exp_e: 0, exp_fall: 0, exp_seed: 0};
        tbl[1] = '{nfr: 4, early_f: 1, skip_f: -1, vary: 1,
                   exp_v: 1, exp_e: 1, exp_fall: 0, exp_seed: 3};
        tbl[2] = '{nfr: 5, early_f: -1, skip_f: 1, vary: 1,
                   exp_v: 1, exp_e: 1, exp_fall: 1, exp_seed: 4};

        #1 rstn = 1'b0;
        #20;
        chk("reset_valid", 256'(valid1), 256'd0);
        chk("reset_pdata", pdata1, 256'd0);
        chk("reset_locked", 256'(locked1), 256'd0);
        chk("reset_frame_err", 256'(ferr1), 256'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        for (int s = 0; s < 3; s++) begin
            en1 = 1'b1;
            repeat (4) @(negedge clk);
            bv = vcnt1; be = ecnt1; bf = lfall1; bq = vq1.size(); bc = chq1.size();
            play1(tbl[s].nfr, tbl[s].early_f, tbl[s].skip_f, tbl[s].vary);
            chk($sformatf("s%0d_valid_count", s), 256'(vcnt1 - bv), 256'(tbl[s].exp_v));
            chk($sformatf("s%0d_err_count", s), 256'(ecnt1 - be), 256'(tbl[s].exp_e));
            chk($sformatf("s%0d_lock_drops", s), 256'(lfall1 - bf), 256'(tbl[s].exp_fall));
            chk($sformatf("s%0d_locked", s), 256'(locked1), 256'd1);
            last = (vq1.size() > bq) ? vq1[vq1.size()-1] : 256'd0;
            chk($sformatf("s%0d_pdata", s), last, gen1(tbl[s].exp_seed));
            if (s == 0) begin
                chk("s0_ch1_word", 256'(last[255:224]), 256'h A500_0001);
                chk("s0_ch8_word", 256'(last[31:0]), 256'h A500_0008);
`ifdef TDM_CHSTREAM_EN
                chk("s0_ch_count", 256'(chq1.size() - bc), 256'd16);
                for (int i = 0; i < 16; i++)
                    chk($sformatf("s0_ch_idx%0d", i),
                        256'((chq1.size() > bc + i) ? chq1[bc+i] : -1), 256'(i % 8));
`endif
            end
            en1 = 1'b0;
            repeat (4) @(negedge clk);
        end

        // enable dropped at bit 100 of the second frame
        en1 = 1'b1;
        repeat (4) @(negedge clk);
        bv = vcnt1; be = ecnt1;
        send1(1'b0, 1'b0);
        send1(1'b0, 1'b0);
        send1(1'b1, 1'b0);
        last = gen1(7);
        for (int b = 0; b < 256; b++) send1(b == 255, last[255-b]);
        for (int b = 0; b < 100; b++) send1(1'b0, last[255-b]);
        en1 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("endrop_locked", 256'(locked1), 256'd0);
        for (int b = 100; b < 256; b++) send1(1'b0, last[255-b]);
        repeat (4) @(negedge clk);
        #1;
        chk("endrop_no_valid", 256'(vcnt1 - bv), 256'd0);
        chk("endrop_pdata_held", pdata1, gen1(4));
        en1 = 1'b1;
        repeat (4) @(negedge clk);
        bv = vcnt1;
        play1(3, -1, -1, 1);
        chk("reenable_valid_count", 256'(vcnt1 - bv), 256'd2);
        chk("reenable_pdata", vq1.size() > 0 ? vq1[vq1.size()-1] : 256'd0, gen1(2));
        chk("reenable_err_count", 256'(ecnt1 - be), 256'd0);
        en1 = 1'b0;
        repeat (4) @(negedge clk);

        // 4x16, FS_DELAY=0, sampled on falling sclk: no first-frame suppression
        fa = 64'h1111_2222_3333_4444;
        fb = 64'h5555_6666_7777_8888;
        en2 = 1'b1;
        repeat (4) @(negedge clk);
        send2(1'b0, 1'b0);
        send2(1'b0, 1'b0);
        for (int b = 0; b < 64; b++) send2(b == 0, fa[63-b]);
        for (int b = 0; b < 64; b++) send2(b == 0, fb[63-b]);
        repeat (10) @(negedge clk);
        #1;
        chk("d2_valid_count", 256'(vcnt2), 256'd2);
        chk("d2_frame_a", 256'(vq2.size() > 0 ? vq2[0] : 64'd0), 256'(fa));
        chk("d2_frame_b", 256'(vq2.size() > 1 ? vq2[1] : 64'd0), 256'(fb));
        chk("d2_err_count", 256'(ecnt2), 256'd0);
        chk("d2_locked", 256'(locked2), 256'd1);
        en2 = 1'b0;

        // asynchronous reset in the middle of a frame
        en1 = 1'b1;
        repeat (4) @(negedge clk);
        send1(1'b0, 1'b0);
        send1(1'b1, 1'b0);
        last = gen1(9);
        for (int b = 0; b < 120; b++) send1(1'b0, last[255-b]);
        @(negedge clk);
        #1;
        chk("pre_reset_locked", 256'(locked1), 256'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("arst_valid", 256'(valid1), 256'd0);
        chk("arst_pdata", pdata1, 256'd0);
        chk("arst_locked", 256'(locked1), 256'd0);
        chk("arst_frame_err", 256'(ferr1), 256'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/tdm_deser.md
Name: tdm_deser

Overview:
Parametrised TDM serial-to-parallel deserializer for the ADC capture path. It is the next generation of the fixed 8-channel, 32-bit deserializer, generalised in channel count, word width and frame-sync offset. It adds selectable sampling edge, continuous frame lock, and frame-sync error detection with automatic resync. The output feeds the AudioNet packetiser as one wide frame word plus a single-cycle valid.

Parameters:
NCH, 8, number of TDM channels per frame (1..16)
WBITS, 32, bits per channel slot (8..32)
FS_DELAY, 1, sclk sample edges between the fs-rise edge and the CH1 MSB (0..WBITS-1)
SYNC_STAGES, 2, synchroniser depth for sclk/fs/tdmin (2..3)

Ports:
clk  in  1  system clock; must be at least 4x sclk
rstn  in  1  reset, asynchronous, active-low
enable  in  1  deserializer enable; low forces IDLE and clears capture state
sample_neg  in  1  0: sample fs/tdmin on sclk rising edge; 1: on falling edge; static while enable high
sclk  in  1  TDM serial clock, asynchronous to clk
fs  in  1  TDM frame sync, active high
tdmin  in  1  TDM serial data, MSB first, CH1 first
valid  out  1  one-clk pulse: pdata updated with a complete frame
pdata  out  NCH*WBITS  frame data; bit TOTAL-1 = CH1 MSB, bit 0 = CHNCH LSB
locked  out  1  high while frame alignment is held
frame_err  out  1  one-clk pulse on fs misalignment or missing fs

Behaviour:
- TOTAL = NCH*WBITS. The index counter is clog2(TOTAL) bits wide and wraps modulo TOTAL.
- sclk, fs and tdmin each pass through SYNC_STAGES flops. A sample edge (samp) is a one-clk strobe when the synchronised sclk shows 0->1 (sample_neg=0) or 1->0 (sample_neg=1).
- fs_rise: fs sampled high on the current samp and low on the previous samp.
- Reset values: valid=0, pdata=0, locked=0, frame_err=0, state=IDLE, index=0, shift register=0.
- States:
  - IDLE: entered on reset or enable=0. Goes to HUNT when enable=1.
  - HUNT: waits for fs_rise. On that samp, loads index with L=(TOTAL-FS_DELAY) mod TOTAL, captures tdmin at slot L, goes to LOCK and raises locked.
  - LOCK: on each samp, captures tdmin into slot bit (TOTAL-1-index), then increments index.
- Frame completion: when slot index TOTAL-1 is captured, the shift register is copied to pdata on the next clk and valid pulses on that same clk.
  - Latency: from the samp capturing CH_NCH LSB to valid is 2 clk.
  - pdata holds its value until the next valid.
- First completion after entering LOCK is suppressed (no valid, pdata unchanged) when FS_DELAY>0, because the partial frame is invalid.
- Alignment check in LOCK, at every samp:
  - fs_rise with index==L: normal; continue.
  - fs_rise with index!=L: frame_err pulses, index reloads to L (resync), the in-progress frame is discarded, locked stays high, and first-frame suppression re-arms.
  - index==L with no fs_rise: frame_err pulses, locked=0, go to HUNT, and the partial frame is discarded.
- Simultaneous events:
  - A completion and a misaligned fs_rise on the same samp: the completion is discarded (no valid) and frame_err wins.
  - When FS_DELAY=0, L=0, so a frame completing and the next fs_rise occur on adjacent samps. This is normal operation.
- enable=0 mid-frame: next clk goes to IDLE, locked=0, the shift register is cleared, and pdata is held. A completion pending in the pipeline is dropped.
- sample_neg change while enabled: undefined, not checked.

Optional Feature:
Macro TDM_CHSTREAM_EN.
- Defined: adds output ports ch_valid (1), ch_idx (clog2(NCH)) and ch_data (WBITS).
  - ch_valid pulses 1 clk after each channel slot's LSB is captured in LOCK.
  - Suppressed under the same conditions as valid.
  - ch_data and ch_idx hold until the next ch_valid. Reset value 0.
- Not defined: the ports are absent, and frame-only behaviour is identical.

Decomposition:
- Package tdm_pkg: state enum (IDLE, HUNT, LOCK), function clog2, localparam helpers TOTAL and L.
- Sub-module tdm_edge_sync: synchroniser chain plus edge detect.
  - Parameter SYNC_STAGES.
  - Inputs: sclk, fs, tdmin, sample_neg.
  - Outputs: samp, fs_s, din_s.

Test Plan:
- Defaults, 3 back-to-back aligned frames, CH k = 32'hA5000000+k -> first valid suppressed; next two valid pulses with pdata[255:224]=32'hA5000001 and pdata[31:0]=32'hA5000008; locked=1; frame_err never pulses.
- NCH=4, WBITS=16, FS_DELAY=0, sample_neg=1, data driven on rising edge -> valid on the first frame; pdata=64'h1111_2222_3333_4444.
- fs rise injected 5 bits early in frame 2 -> frame_err pulses once, no valid for frame 2, locked stays 1, frame 4 data correct.
- fs suppressed for one frame -> frame_err at index L, locked=0, state HUNT, relock on the next fs, valid resumes one frame later.
- enable dropped at bit 100 -> locked=0 next clk, no valid, pdata unchanged; re-enable -> normal relock.
- rstn asserted mid-frame -> all outputs 0 immediately (async); with TDM_CHSTREAM_EN, 8 ch_valid pulses per frame, ch_idx 0..7 in order.
